// File: rtl/price_feed_arbiter.sv
// price_feed_arbiter: round-robin sequencer that shares one stock-price engine among NUM_REQ
// feeds. It issues one sample at a time and returns the engine result tagged with the feed ID.
// A wait-cycle watchdog aborts a request whose engine never completes.
module price_feed_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_price,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          stock_price,
    output logic                       data_ready,
    input  logic                       eng_done,
    input  logic [DATA_W-1:0]          eng_result,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_REQ - 1);
    localparam logic [IdW:0]    SumWrap = (IdW + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StErr
    } state_e;

    state_e          state_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [IdW-1:0]  gnt_id_q;
    logic [CntW-1:0] wait_cnt_q;

    logic [NUM_REQ-1:0] rot_valid;
    logic               pick_found;
    logic [IdW-1:0]     pick_off;
    logic [IdW:0]       pick_sum;
    logic [IdW-1:0]     pick_id;
    logic [DATA_W-1:0]  pick_price;
    logic [IdW-1:0]     rr_ptr_next;

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit,
    // then map the offset back to an absolute feed ID and select that feed's price.
    always_comb begin
        rot_valid  = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        pick_found = |req_valid;
        pick_off   = '0;
        // Descending scan so the smallest offset is the one left standing.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick_off = IdW'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= SumWrap) begin
            pick_sum = pick_sum - SumWrap;
        end
        pick_id    = pick_sum[IdW-1:0];
        pick_price = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IdW'(i)) begin
                pick_price = req_price[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves just past the feed that was served (or dropped) so it cannot starve others.
    always_comb begin
        rr_ptr_next = (gnt_id_q == IdLast) ? '0 : gnt_id_q + IdW'(1);
    end

    // Sequencer FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            wait_cnt_q  <= '0;
            req_ready   <= '0;
            stock_price <= '0;
            data_ready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_ready   <= '0;
            data_ready  <= 1'b0;
            rsp_valid   <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        gnt_id_q    <= pick_id;
                        stock_price <= pick_price;
                        req_ready   <= NUM_REQ'(1) << pick_id;
                        data_ready  <= 1'b1;
                        busy        <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q + CntW'(1);
                    // Completion on the last allowed cycle still beats the watchdog.
                    if (eng_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gnt_id_q;
                        rsp_result <= eng_result;
                        state_q    <= StResp;
                    end else if (wait_cnt_q == CntLast) begin
                        timeout_err <= 1'b1;
                        rsp_id      <= gnt_id_q;
                        state_q     <= StErr;
                    end
                end
                StResp, StErr: begin
                    rr_ptr_q <= rr_ptr_next;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/price_feed_arbiter.md
# price_feed_arbiter

Round-robin arbiter and sequencer that shares the single stock-price computation engine among NUM_REQ independent price feeds. Each feed's sample is granted in turn and issued to the engine as a one-cycle `data_ready` pulse with `stock_price`. The block then waits for the engine's completion and returns the result tagged with the originating feed ID. A watchdog recovers from an engine that never completes.

## Interface
- NUM_REQ, 4: number of price feeds (2..8).
- DATA_W, 32: price/result width.
- TIMEOUT, 255: max WAIT cycles before abort (≥2).
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  feed i has a sample pending; held until req_ready[i].
- req_price  in  NUM_REQ*DATA_W  feed i price at bits [i*DATA_W +: DATA_W]; stable while req_valid[i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept of the granted feed.
- stock_price  out  DATA_W  price issued to engine.
- data_ready  out  1  one-cycle start pulse to engine.
- eng_done  in  1  engine completion strobe.
- eng_result  in  DATA_W  engine result, valid with eng_done.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  $clog2(NUM_REQ)  feed ID of rsp_result / timeout.
- rsp_result  out  DATA_W  latched engine result.
- timeout_err  out  1  one-cycle abort strobe; rsp_id identifies the feed.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR. All outputs registered (Moore).
- IDLE: if any req_valid, pick the first set bit scanning rr_ptr, rr_ptr+1, … with wrap mod NUM_REQ. Latch gnt_id and that price, then go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): data_ready=1, req_ready[gnt_id]=1, stock_price=latched price. Wait counter cleared. Go to WAIT.
- WAIT: counter increments each cycle.
  - If eng_done: latch eng_result, go to RESP.
  - Else if counter==TIMEOUT-1: go to ERR.
  - eng_done on the final cycle wins over timeout.
- RESP (1 cycle): rsp_valid=1, rsp_id=gnt_id, rsp_result=latched result. rr_ptr←(gnt_id+1) mod NUM_REQ. Go to IDLE.
- ERR (1 cycle): timeout_err=1, rsp_id=gnt_id. rr_ptr advances as in RESP; the sample is dropped, not retried. Go to IDLE.
- eng_done outside WAIT is ignored.
- stock_price holds its last issued value until the next ISSUE.
- rsp_result and rsp_id hold their values between strobes.
- req_valid deasserting after grant has no effect; the grant was already taken.
- Reset (any state, including mid-WAIT): on the next edge, state=IDLE, rr_ptr=0, counter=0, all outputs 0. The in-flight request is abandoned with no response. A late eng_done is ignored.

## Timing
- Reset values: req_ready=0, stock_price=0, data_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, timeout_err=0, busy=0.
- Grant latency: req_valid sampled in IDLE at edge k → req_ready and data_ready high during cycle k+1 → WAIT from k+2.
- Response latency: eng_done sampled at edge m → rsp_valid high cycle m+1 → IDLE at m+2. The next data_ready is no earlier than m+3.
- Minimum period per transaction: 4 cycles, with eng_done on the first WAIT cycle.
- Timeout: eng_done is never seen across TIMEOUT WAIT cycles → timeout_err high on the cycle after the last WAIT cycle.
- At most one transaction is outstanding. busy is high from ISSUE through RESP/ERR inclusive.

## Test plan
- Single feed: req_valid=4'b0010, price 32'h0000_1234; engine returns 32'h0000_0ABC 3 cycles after data_ready → one data_ready with stock_price=32'h1234, req_ready=4'b0010, then rsp_valid with rsp_id=1, rsp_result=32'hABC.
- All four feeds valid continuously from reset; engine done 1 cycle after each issue → grants in order 0,1,2,3,0. Consecutive data_ready pulses exactly 4 cycles apart.
- Fairness: after feed 2 is served, feeds 0 and 3 are pending → feed 3 granted before feed 0.
- Timeout with TIMEOUT=8, eng_done never asserted → timeout_err pulse with rsp_id=gnt_id, 8 WAIT cycles after WAIT entry; no rsp_valid; next feed is then granted.
- Boundary: eng_done on WAIT cycle 7 with TIMEOUT=8 → rsp_valid, no timeout_err. A stray eng_done while IDLE → no rsp_valid.
- n_rst low during WAIT, then eng_done after reset → all outputs 0, busy=0, no response. The next grant starts from feed 0.
